// File: rtl/adiabatic_clock_sequencer_if.sv
`default_nettype none
// ==========================================================================
// Module   : adiabatic_clock_sequencer_if
// Brief    : Request/status bundle between requester and clock sequencer.
// Revision : 1.0
// ==========================================================================
interface adiabatic_clock_sequencer_if;
   logic start_valid;
   logic start_ready;
   logic halt;
   logic done;
   logic busy;

   modport master (
      output start_valid,
      output halt,
      input  start_ready,
      input  done,
      input  busy
   );

   modport slave (
      input  start_valid,
      input  halt,
      output start_ready,
      output done,
      output busy
   );
endinterface
`default_nettype wire

// File: rtl/adiabatic_clock_sequencer.sv
`default_nettype none
// ==========================================================================
// Module   : adiabatic_clock_sequencer
// Brief    : Four-phase power-clock sequencer with per-stage token tracking.
// Revision : 1.0
// ==========================================================================
module adiabatic_clock_sequencer #(
   parameter int NSTAGES   = 4,
   parameter int PHASE_CYC = 2
) (
   input  wire                         clk,
   input  wire                         rst,
   adiabatic_clock_sequencer_if.slave  bus,
   output logic [NSTAGES-1:0]          clkpos,
   output logic [NSTAGES-1:0]          clkneg,
   output logic [2*NSTAGES-1:0]        phase
);

   localparam int              c_CW      = (PHASE_CYC > 1) ? $clog2(PHASE_CYC) : 1;
   localparam logic [c_CW-1:0] c_CMAX    = c_CW'(PHASE_CYC - 1);
   localparam logic [1:0]      c_PH_HOLD = 2'd1;
   localparam logic [1:0]      c_PH_WAIT = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_state_nx;
   logic [c_CW-1:0]    r_cnt;
   logic [1:0]         r_gphase;
   logic [1:0]         w_gnext;
   logic [NSTAGES-1:0] w_token;
   logic [NSTAGES-1:0] w_tin;
   logic [NSTAGES-1:0] w_enter;
   logic               w_adv;
   logic               w_slot;
   logic               w_ready;
   logic               w_accept;

   assign w_adv    = (r_state != S_IDLE) && (r_cnt == c_CMAX);
   assign w_gnext  = r_gphase + 2'd1;
   assign w_slot   = (r_gphase == 2'd3) && (r_cnt == c_CMAX);
   assign w_accept = bus.start_valid && w_ready;

   always_comb begin
      w_state_nx = r_state;
      w_ready    = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_ready = 1'b1;
            if (bus.start_valid) w_state_nx = S_RUN;
         end
         S_RUN: begin
            w_ready = w_slot && !bus.halt;
            if (w_slot && !(bus.start_valid && !bus.halt)) w_state_nx = S_DRAIN;
         end
         S_DRAIN: begin
            if (w_token == '0) w_state_nx = S_IDLE;
         end
         default: w_state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nx;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt    <= '0;
         r_gphase <= '0;
      end else if (r_state == S_IDLE || w_state_nx == S_IDLE) begin
         r_cnt    <= '0;
         r_gphase <= '0;
      end else if (r_cnt == c_CMAX) begin
         r_cnt    <= '0;
         r_gphase <= w_gnext;
      end else begin
         r_cnt    <= r_cnt + c_CW'(1);
      end
   end

   // A stage's rail is live exactly while it carries a token; both are
   // sampled only at its RAMP_UP boundary, so a rail never parks mid-cycle.
   generate
      for (genvar i = 0; i < NSTAGES; i++) begin : g_stage
         localparam logic [1:0] c_OFF = 2'(i % 4);
         logic       r_tok;
         logic [1:0] w_ph;

         if (i == 0) begin : g_head
            assign w_tin[i]   = w_accept;
            assign w_enter[i] = ((r_state == S_IDLE) && w_accept) ||
                                (w_adv && (w_gnext == c_OFF));
         end else begin : g_body
            assign w_tin[i]   = w_token[i-1];
            assign w_enter[i] = w_adv && (w_gnext == c_OFF);
         end

         always_ff @(posedge clk or posedge rst) begin
            if (rst)             r_tok <= 1'b0;
            else if (w_enter[i]) r_tok <= w_tin[i];
         end

         assign w_token[i]     = r_tok;
         assign w_ph           = r_tok ? (r_gphase - c_OFF) : c_PH_WAIT;
         assign phase[2*i +: 2] = w_ph;
         assign clkpos[i]      = r_tok && !w_ph[1];
         assign clkneg[i]      = ~clkpos[i];
      end
   endgenerate

   assign bus.start_ready = w_ready;
   assign bus.busy        = (r_state != S_IDLE);
   assign bus.done        = w_token[NSTAGES-1] && (r_cnt == '0) &&
                            (phase[2*(NSTAGES-1) +: 2] == c_PH_HOLD);

endmodule
`default_nettype wire

// File: tb/tb_adiabatic_clock_sequencer.sv
`default_nettype none
// ==========================================================================
// Module   : tb_adiabatic_clock_sequencer
// Brief    : Directed checks of the sequencer at default and 1-stage configs.
// Revision : 1.0
// ==========================================================================
module tb_adiabatic_clock_sequencer;

   logic       clk;
   logic       rst;
   logic [3:0] clkpos;
   logic [3:0] clkneg;
   logic [7:0] phase;
   logic [0:0] clkpos1;
   logic [0:0] clkneg1;
   logic [1:0] phase1;

   int tests_run;
   int tests_failed;

   adiabatic_clock_sequencer_if bus();
   adiabatic_clock_sequencer_if bus1();

   adiabatic_clock_sequencer #(.NSTAGES(4), .PHASE_CYC(2)) u_dut (
      .clk(clk), .rst(rst), .bus(bus.slave),
      .clkpos(clkpos), .clkneg(clkneg), .phase(phase)
   );

   adiabatic_clock_sequencer #(.NSTAGES(1), .PHASE_CYC(3)) u_dut1 (
      .clk(clk), .rst(rst), .bus(bus1.slave),
      .clkpos(clkpos1), .clkneg(clkneg1), .phase(phase1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic wait_idle(output bit ok);
      ok = 1'b0;
      for (int n = 0; n < 60; n++) begin
         @(posedge clk); #2;
         if (!bus.busy && !bus1.busy) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #2;
      tests_run++;
      if (phase !== 8'hFF || clkpos !== 4'h0 || clkneg !== 4'hF) begin
         tests_failed++;
         $display("FAIL reset_rails phase=%h clkpos=%h clkneg=%h exp FF/0/F", phase, clkpos, clkneg);
      end
      #1 rst = 1'b0;
      #1;
      tests_run++;
      if (bus.start_ready !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_status ready=%b busy=%b done=%b exp 1/0/0", bus.start_ready, bus.busy, bus.done);
      end
   endtask

   task automatic test_single();
      logic       erdy, edone, ebusy, ep3;
      logic [1:0] eph;
      bit         ok;
      for (int c = 0; c < 18; c++) begin
         @(posedge clk); #1;
         bus.start_valid = (c == 0);
         #1;
         erdy  = (c == 0) || (c == 8) || (c >= 16);
         edone = (c == 9);
         ebusy = (c >= 1) && (c <= 15);
         ep3   = (c >= 7) && (c <= 10);
         eph   = (c >= 1 && c <= 8) ? 2'((c - 1) / 2) : 2'd3;
         tests_run++;
         if (bus.start_ready !== erdy || bus.done !== edone || bus.busy !== ebusy) begin
            tests_failed++;
            $display("FAIL single_status c=%0d ready=%b done=%b busy=%b exp %b/%b/%b", c, bus.start_ready, bus.done, bus.busy, erdy, edone, ebusy);
         end
         tests_run++;
         if (phase[1:0] !== eph || clkpos[3] !== ep3) begin
            tests_failed++;
            $display("FAIL single_phase c=%0d ph0=%0d clkpos3=%b exp %0d/%b", c, phase[1:0], clkpos[3], eph, ep3);
         end
      end
      tests_run++;
      if (phase !== 8'hFF || clkneg !== 4'hF) begin
         tests_failed++;
         $display("FAIL single_parked phase=%h clkneg=%h exp FF/F", phase, clkneg);
      end
      wait_idle(ok);
      tests_run++;
      if (!ok) begin tests_failed++; $display("FAIL single_idle timeout got busy exp idle"); end
   endtask

   task automatic test_back_to_back();
      logic erdy, edone, ebusy, ep0, ep1;
      bit   ok;
      for (int c = 0; c < 34; c++) begin
         @(posedge clk); #1;
         bus.start_valid = (c <= 16);
         #1;
         erdy  = (c == 0) || (c == 8) || (c == 16) || (c == 24) || (c >= 32);
         edone = (c == 9) || (c == 17) || (c == 25);
         ebusy = (c >= 1) && (c <= 31);
         ep0   = (c >= 1) && (c <= 24) && (((c - 1) % 8) < 4);
         ep1   = (c >= 3) && (c <= 26) && (((c - 3) % 8) < 4);
         tests_run++;
         if (bus.start_ready !== erdy || bus.done !== edone || bus.busy !== ebusy) begin
            tests_failed++;
            $display("FAIL b2b_status c=%0d ready=%b done=%b busy=%b exp %b/%b/%b", c, bus.start_ready, bus.done, bus.busy, erdy, edone, ebusy);
         end
         tests_run++;
         if (clkpos[0] !== ep0 || clkpos[1] !== ep1 || clkneg[1:0] !== ~{ep1, ep0}) begin
            tests_failed++;
            $display("FAIL b2b_rails c=%0d clkpos=%b clkneg=%b exp pos %b%b", c, clkpos, clkneg, ep1, ep0);
         end
      end
      wait_idle(ok);
      tests_run++;
      if (!ok) begin tests_failed++; $display("FAIL b2b_idle timeout got busy exp idle"); end
   endtask

   task automatic test_halt();
      logic erdy, edone, ebusy;
      bit   ok;
      for (int c = 0; c < 18; c++) begin
         @(posedge clk); #1;
         bus.start_valid = (c <= 12);
         bus.halt        = (c >= 4);
         #1;
         erdy  = (c == 0) || (c >= 16);
         edone = (c == 9);
         ebusy = (c >= 1) && (c <= 15);
         tests_run++;
         if (bus.start_ready !== erdy || bus.done !== edone || bus.busy !== ebusy) begin
            tests_failed++;
            $display("FAIL halt_status c=%0d ready=%b done=%b busy=%b exp %b/%b/%b", c, bus.start_ready, bus.done, bus.busy, erdy, edone, ebusy);
         end
      end
      tests_run++;
      if (phase !== 8'hFF || clkpos !== 4'h0) begin
         tests_failed++;
         $display("FAIL halt_parked phase=%h clkpos=%h exp FF/0", phase, clkpos);
      end
      bus.halt = 1'b0;
      wait_idle(ok);
      tests_run++;
      if (!ok) begin tests_failed++; $display("FAIL halt_idle timeout got busy exp idle"); end
   endtask

   task automatic test_rst_mid();
      logic edone;
      bit   ok;
      for (int c = 0; c < 6; c++) begin
         @(posedge clk); #1;
         bus.start_valid = (c == 0);
         #1;
      end
      tests_run++;
      if (phase[1:0] !== 2'd2 || bus.busy !== 1'b1) begin
         tests_failed++;
         $display("FAIL rstmid_pre ph0=%0d busy=%b exp 2/1", phase[1:0], bus.busy);
      end
      rst = 1'b1;
      #1;
      tests_run++;
      if (clkpos !== 4'h0 || clkneg !== 4'hF || phase !== 8'hFF || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
         tests_failed++;
         $display("FAIL rstmid_async clkpos=%h clkneg=%h phase=%h busy=%b done=%b exp 0/F/FF/0/0", clkpos, clkneg, phase, bus.busy, bus.done);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #2;
         tests_run++;
         if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL rstmid_ghost k=%0d done=%b busy=%b exp 0/0", c, bus.done, bus.busy);
         end
      end
      for (int c = 0; c < 11; c++) begin
         @(posedge clk); #1;
         bus.start_valid = (c == 0);
         #1;
         edone = (c == 9);
         tests_run++;
         if (bus.done !== edone) begin
            tests_failed++;
            $display("FAIL rstmid_next c=%0d done=%b exp %b", c, bus.done, edone);
         end
      end
      wait_idle(ok);
      tests_run++;
      if (!ok) begin tests_failed++; $display("FAIL rstmid_idle timeout got busy exp idle"); end
   endtask

   task automatic test_single_stage();
      logic       erdy, edone;
      logic [1:0] eph;
      bit         ok;
      for (int c = 0; c < 18; c++) begin
         @(posedge clk); #1;
         bus1.start_valid = (c <= 12);
         #1;
         erdy  = (c == 0) || (c == 12);
         edone = (c == 4) || (c == 16);
         eph   = (c >= 1) ? 2'(((c - 1) / 3) % 4) : 2'd3;
         tests_run++;
         if (bus1.start_ready !== erdy || bus1.done !== edone || phase1 !== eph) begin
            tests_failed++;
            $display("FAIL one_stage c=%0d ready=%b done=%b ph=%0d exp %b/%b/%0d", c, bus1.start_ready, bus1.done, phase1, erdy, edone, eph);
         end
         tests_run++;
         if (clkpos1[0] !== !eph[1] || clkneg1[0] !== eph[1]) begin
            tests_failed++;
            $display("FAIL one_stage_rail c=%0d clkpos=%b clkneg=%b exp %b/%b", c, clkpos1, clkneg1, !eph[1], eph[1]);
         end
      end
      bus1.start_valid = 1'b0;
      wait_idle(ok);
      tests_run++;
      if (!ok) begin tests_failed++; $display("FAIL one_stage_idle timeout got busy exp idle"); end
   endtask

   task automatic test_late_valid();
      logic erdy, edone;
      bit   ok;
      for (int c = 0; c < 19; c++) begin
         @(posedge clk); #1;
         bus.start_valid = (c == 0) || (c >= 3 && c <= 8);
         #1;
         erdy  = (c == 0) || (c == 8) || (c == 16);
         edone = (c == 9) || (c == 17);
         tests_run++;
         if (bus.start_ready !== erdy || bus.done !== edone) begin
            tests_failed++;
            $display("FAIL late_valid c=%0d ready=%b done=%b exp %b/%b", c, bus.start_ready, bus.done, erdy, edone);
         end
      end
      wait_idle(ok);
      tests_run++;
      if (!ok) begin tests_failed++; $display("FAIL late_idle timeout got busy exp idle"); end
   endtask

   initial begin
      tests_run        = 0;
      tests_failed     = 0;
      rst              = 1'b1;
      bus.start_valid  = 1'b0;
      bus.halt         = 1'b0;
      bus1.start_valid = 1'b0;
      bus1.halt        = 1'b0;
      test_reset();
      test_single();
      test_back_to_back();
      test_halt();
      test_rst_mid();
      test_single_stage();
      test_late_valid();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
`default_nettype wire
